// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
//
// Contents:
//   NREG_DEF, ADDR_W_DEF, DATA_W_DEF : default geometry of the register file
//   state_e                          : arbiter FSM states (CLEAR, ARB)
package regfile_pkg;

    localparam int NREG_DEF   = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;

    // CLEAR walks every address writing zero; ARB serves the two requesters.
    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (pointer returns to requester 0)
//   valid_i  in   [1:0] request lines
//   advance  in   a grant was consumed this cycle; rotate the pointer
//   grant_o  out  [1:0] one-hot grant, purely combinational from valid and pointer
module rr_arbiter2
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    input  logic       advance,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // A lone requester always wins; on contention the pointer picks the winner.
    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // After a handshake the pointer moves to whichever requester lost.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter with a built-in clear sequence.
// After reset (or a clr_req pulse) every entry is written with zero, one per
// cycle; afterwards two requesters share the single write port round-robin.
// All rf_* outputs are registered, so a handshake appears one cycle later.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   clr_req / clr_busy            restart clear / clear in progress
//   reqN_valid/addr/data/ready    requester N (0,1) valid-ready write channel
//   rf_we, rf_waddr, rf_datain    registered register-file write port
//   last_grant                    index of the most recently granted requester
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_datain,
    output logic              last_grant
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_datain_q, rf_datain_d;

    logic [1:0] grant;
    logic       handshake;

    // Grants are only honoured in ARB, so the pointer must not move in CLEAR.
    assign handshake = (state_q == ARB) && (grant != 2'b00);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .valid_i ({req1_valid, req0_valid}),
        .advance (handshake),
        .grant_o (grant)
    );

    assign req0_ready = (state_q == ARB) && grant[0];
    assign req1_ready = (state_q == ARB) && grant[1];
    assign clr_busy   = (state_q == CLEAR);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_datain  = rf_datain_q;
    assign last_grant = last_grant_q;

    // Next-state and write-port loading. Address/data hold when no write is
    // issued; the clear counter wraps to zero on its own at NREG-1.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_datain_d  = rf_datain_q;

        unique case (state_q)
            CLEAR: begin
                rf_we_d     = 1'b1;
                rf_waddr_d  = clr_cnt_q;
                rf_datain_d = '0;
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(NREG - 1)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (handshake) begin
                    rf_we_d      = 1'b1;
                    rf_waddr_d   = grant[1] ? req1_addr : req0_addr;
                    rf_datain_d  = grant[1] ? req1_data : req0_data;
                    last_grant_d = grant[1];
                end
                // A same-cycle handshake above still completes before clearing.
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_datain_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_datain_q  <= rf_datain_d;
        end
    end

endmodule
